// File: rtl/rom_access_arbiter.sv
// Two-port round-robin arbiter in front of a single ROM: requester A (fetch)
// and B (load) share one fixed-latency read path.
module rom_access_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_data,

    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_data,

    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;   // 0 = A, 1 = B
    logic                ptr_q, ptr_d;       // preferred port on a tie
    logic                gnt_q, gnt_d;       // first ACCESS cycle marker
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   a_data_q, a_data_d;
    logic [DATA_W-1:0]   b_data_q, b_data_d;
    logic                sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        gnt_d    = 1'b0;
        addr_d   = addr_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        sel      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // A lone requester wins outright; a tie goes to the pointer.
                    // Either way the pointer then names the port that lost.
                    sel     = (a_req && b_req) ? ptr_q : b_req;
                    owner_d = sel;
                    ptr_d   = ~sel;
                    addr_d  = sel ? b_addr : a_addr;
                    cnt_d   = CNT_LOAD;
                    gnt_d   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        b_data_d = rom_data;
                    end else begin
                        a_data_d = rom_data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_cs   = (state_q == ACCESS);
    assign rom_oe   = (state_q == ACCESS);
    assign rom_addr = (state_q == ACCESS) ? addr_q : '0;
    assign busy     = (state_q != IDLE);

    assign a_gnt    = gnt_q & ~owner_q;
    assign b_gnt    = gnt_q &  owner_q;
    assign a_valid  = (state_q == DONE) & ~owner_q;
    assign b_valid  = (state_q == DONE) &  owner_q;
    assign a_data   = a_data_q;
    assign b_data   = b_data_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: three instances (WAIT_CYCLES 2, 1, 15)
// share clock/reset; a ROM model answers reads and a queue holds expected returns.
module tb_rom_access_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic          a_req   [3];
    logic [AW-1:0] a_addr  [3];
    logic          a_gnt   [3];
    logic          a_valid [3];
    logic [DW-1:0] a_data  [3];
    logic          b_req   [3];
    logic [AW-1:0] b_addr  [3];
    logic          b_gnt   [3];
    logic          b_valid [3];
    logic [DW-1:0] b_data  [3];
    logic [AW-1:0] rom_addr[3];
    logic          rom_cs  [3];
    logic          rom_oe  [3];
    logic [DW-1:0] rom_data[3];
    logic          busy    [3];

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        if (a == 32'h8) return 64'hD280_0000;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rom_access_arbiter #(
            .WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15),
            .ADDR_W     (AW),
            .DATA_W     (DW)
        ) dut (
            .clock   (clock),
            .reset   (reset),
            .a_req   (a_req[g]),
            .a_addr  (a_addr[g]),
            .a_gnt   (a_gnt[g]),
            .a_valid (a_valid[g]),
            .a_data  (a_data[g]),
            .b_req   (b_req[g]),
            .b_addr  (b_addr[g]),
            .b_gnt   (b_gnt[g]),
            .b_valid (b_valid[g]),
            .b_data  (b_data[g]),
            .rom_addr(rom_addr[g]),
            .rom_cs  (rom_cs[g]),
            .rom_oe  (rom_oe[g]),
            .rom_data(rom_data[g]),
            .busy    (busy[g])
        );
        // Undriven bus unless output-enabled, so a read without OE captures X.
        assign rom_data[g] = rom_oe[g] ? rom_val(rom_addr[g]) : 'x;
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic push(input logic port, input logic [AW-1:0] addr);
        exp_t e;
        e.port = port;
        e.data = rom_val(addr);
        sb.push_back(e);
    endtask

    task automatic sb_pop_check(input int d);
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid_onehot", 64'(a_valid[d] & b_valid[d]), 64'd0);
            chk("valid_port", 64'(b_valid[d]), 64'(e.port));
            chk("valid_data", e.port ? b_data[d] : a_data[d], e.data);
        end
    endtask

    task automatic wait_gnt(input int d, input int maxc, output logic port);
        int n = 0;
        while (!(a_gnt[d] || b_gnt[d]) && n < maxc) begin
            tick();
            n++;
        end
        chk("gnt_seen", 64'(a_gnt[d] | b_gnt[d]), 64'd1);
        chk("gnt_onehot", 64'(a_gnt[d] & b_gnt[d]), 64'd0);
        port = b_gnt[d];
    endtask

    task automatic wait_valid(input int d, input int maxc, output int n);
        n = 0;
        while (!(a_valid[d] || b_valid[d]) && n < maxc) begin
            tick();
            n++;
        end
        chk("valid_seen", 64'(a_valid[d] | b_valid[d]), 64'd1);
        sb_pop_check(d);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_ctrl", {57'd0, a_gnt[d], b_gnt[d], a_valid[d], b_valid[d],
                         rom_cs[d], rom_oe[d], busy[d]}, 64'd0);
        chk("rst_a_data", a_data[d], 64'd0);
        chk("rst_b_data", b_data[d], 64'd0);
        chk("rst_rom_addr", 64'(rom_addr[d]), 64'd0);
    endtask

    initial begin
        logic port;
        int   n;
        int   last;
        int   lat [3];
        lat = '{2, 1, 15};

        for (int i = 0; i < 3; i++) begin
            a_req[i] = 1'b0; b_req[i] = 1'b0;
            a_addr[i] = '0;  b_addr[i] = '0;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk_reset_outputs(i);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Continuous dual request: A,B,A,B, four cycles apart
        a_addr[0] = 32'h100; b_addr[0] = 32'h200;
        a_req[0] = 1'b1; b_req[0] = 1'b1;
        push(1'b0, 32'h100); push(1'b1, 32'h200);
        push(1'b0, 32'h100); push(1'b1, 32'h200);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(0, 20, port);
            chk("rr_port", 64'(port), 64'(k % 2));
            if (k > 0) chk("rr_spacing", 64'(cyc - last), 64'd4);
            last = cyc;
            if (k == 3) begin
                a_req[0] = 1'b0; b_req[0] = 1'b0;
            end
            wait_valid(0, 20, n);
            chk("rr_latency", 64'(n), 64'd2);
        end
        tick();

        // Single A read, cycle by cycle
        a_addr[0] = 32'h8; a_req[0] = 1'b1;
        push(1'b0, 32'h8);
        tick();
        chk("c1_ctrl", {59'd0, a_gnt[0], b_gnt[0], rom_cs[0], rom_oe[0], busy[0]}, 64'b10111);
        chk("c1_rom_addr", 64'(rom_addr[0]), 64'h8);
        a_req[0] = 1'b0; a_addr[0] = '1;
        tick();
        chk("c2_ctrl", {59'd0, a_gnt[0], a_valid[0], rom_cs[0], rom_oe[0], busy[0]}, 64'b00111);
        chk("c2_rom_addr", 64'(rom_addr[0]), 64'h8);
        tick();
        chk("c3_valid", 64'(a_valid[0]), 64'd1);
        sb_pop_check(0);
        chk("c3_ctrl", {61'd0, rom_cs[0], rom_oe[0], busy[0]}, 64'b001);
        chk("c3_rom_addr", 64'(rom_addr[0]), 64'd0);
        tick();
        chk("c4_idle", {62'd0, busy[0], a_valid[0]}, 64'd0);

        // B granted, then req dropped and addr changed mid-access
        b_addr[0] = 32'h300; b_req[0] = 1'b1;
        push(1'b1, 32'h300);
        wait_gnt(0, 10, port);
        chk("b_port", 64'(port), 64'd1);
        b_req[0] = 1'b0; b_addr[0] = 32'h777;
        tick();
        chk("b_hold_addr", 64'(rom_addr[0]), 64'h300);
        wait_valid(0, 10, n);
        chk("a_data_kept", a_data[0], rom_val(32'h8));
        tick();

        // Reset in the second ACCESS cycle aborts the read
        a_addr[0] = 32'h40; a_req[0] = 1'b1;
        wait_gnt(0, 10, port);
        tick();
        a_req[0] = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs(0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_valid_after_abort", 64'(a_valid[0] | b_valid[0] | busy[0]), 64'd0);
        end
        a_addr[0] = 32'h10; b_addr[0] = 32'h20;
        a_req[0] = 1'b1; b_req[0] = 1'b1;
        push(1'b0, 32'h10);
        wait_gnt(0, 10, port);
        chk("post_reset_first_a", 64'(port), 64'd0);
        a_req[0] = 1'b0; b_req[0] = 1'b0;
        wait_valid(0, 10, n);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dropped_b_silent", 64'(a_gnt[0] | b_gnt[0] | a_valid[0] | b_valid[0]), 64'd0);
        end

        // Latency extremes on the WAIT_CYCLES=1 and =15 instances
        for (int d = 1; d < 3; d++) begin
            a_addr[d] = 32'h50; a_req[d] = 1'b1;
            push(1'b0, 32'h50);
            tick();
            chk("ext_gnt", 64'(a_gnt[d]), 64'd1);
            a_req[d] = 1'b0;
            wait_valid(d, 40, n);
            chk("ext_latency", 64'(n + 1), 64'(lat[d] + 1));
            tick(); tick();
            b_addr[d] = 32'h60; b_req[d] = 1'b1;
            push(1'b1, 32'h60);
            wait_gnt(d, 10, port);
            b_req[d] = 1'b0;
            wait_valid(d, 40, n);
            chk("ext_a_data_kept", a_data[d], rom_val(32'h50));
            tick(); tick();
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, ROM access cycles with chip select asserted (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 64, data width.
REQ-004 SHALL have port clock  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports a_req  input  1, a_addr  input  ADDR_W  for requester A (instruction fetch) access request and address.
REQ-007 SHALL have ports a_gnt  output  1, a_valid  output  1, a_data  output  DATA_W  for the A grant pulse, data-valid pulse and returned data.
REQ-008 SHALL have ports b_req, b_addr, b_gnt, b_valid, b_data with the same directions, widths and meanings for requester B (data load).
REQ-009 SHALL have ports rom_addr  output  ADDR_W, rom_cs  output  1, rom_oe  output  1  driving the ROM address, chip select and output enable.
REQ-010 SHALL have port rom_data  input  DATA_W  carrying ROM read data.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ACCESS, DONE plus a 4-bit wait counter, a 1-bit owner register and a 1-bit priority pointer (0 = A preferred).
REQ-013 In IDLE, with no request sampled, SHALL remain in IDLE with rom_cs=rom_oe=0.
REQ-014 In IDLE, if exactly one of a_req/b_req is high at an edge, SHALL grant that port, latch its address, and set the pointer to the other port.
REQ-015 In IDLE, if both requests are high, SHALL grant the port named by the pointer, then flip the pointer (round-robin).
REQ-016 On a grant edge, SHALL enter ACCESS, load the counter with WAIT_CYCLES-1, and assert the owner's gnt for exactly the first ACCESS cycle.
REQ-017 Throughout ACCESS, SHALL drive rom_addr with the latched address and hold rom_cs=rom_oe=1; rom_addr SHALL be 0 outside ACCESS.
REQ-018 In ACCESS, SHALL decrement the counter each cycle; on the edge ending the cycle with counter=0, SHALL capture rom_data into the owner's data register and enter DONE.
REQ-019 In DONE, SHALL assert the owner's valid for exactly one cycle, keep rom_cs=rom_oe=0, and return to IDLE on the next edge.
REQ-020 Latency: request sampled at edge E, gnt in cycle E+1, valid in cycle E+1+WAIT_CYCLES; minimum request-to-request spacing 2+WAIT_CYCLES cycles.
REQ-021 Once granted, an access SHALL complete even if the requester deasserts req or changes addr; address/req changes after grant SHALL have no effect.
REQ-022 A request dropped before it is sampled in IDLE SHALL produce no gnt and no valid.
REQ-023 A request arriving while busy SHALL wait; the requester SHALL hold req and addr until gnt.
REQ-024 a_data/b_data SHALL hold their last captured value until that port's next capture; the non-owner's data SHALL never change.
REQ-025 At most one of a_gnt/b_gnt and at most one of a_valid/b_valid SHALL be high in any cycle.

Reset
REQ-026 While reset is high, SHALL force state IDLE, counter 0, pointer 0, owner 0, and all outputs (gnt, valid, data, rom_addr, rom_cs, rom_oe, busy) to 0, independent of clock.
REQ-027 Reset asserted mid-ACCESS or in DONE SHALL abort the access; no valid SHALL be produced for it after reset release.
REQ-028 After reset release, the first simultaneous request SHALL be granted to A.

Verification
REQ-029 Single A request, WAIT_CYCLES=2, a_addr=0x0008, ROM returns 0xD2800000 -> a_gnt in cycle 1, rom_cs=rom_oe=1 cycles 1-2, a_valid in cycle 3 with a_data=0xD2800000, busy low in cycle 4.
REQ-030 a_req and b_req held high together continuously -> grants alternate A,B,A,B; each valid returns on the matching port; spacing between gnts 4 cycles.
REQ-031 B granted, then b_req dropped and b_addr changed during ACCESS -> rom_addr stays at latched value, b_valid still pulses with data from original address.
REQ-032 Reset asserted in second ACCESS cycle -> rom_cs, rom_oe, busy drop immediately; no a_valid/b_valid afterward; next dual request grants A.
REQ-033 WAIT_CYCLES=1 and WAIT_CYCLES=15 -> valid appears at cycle 2 and cycle 16 after the sampling edge respectively; a_data unchanged by intervening B accesses.
